// File: rtl/comparador_bcd_serial.sv
// Digit-serial packed-BCD magnitude comparator, MSD first.
// Stops at the first differing digit; flags non-BCD input digits.
module comparador_bcd_serial #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] A,
   input  logic [4*DIGITS-1:0] B,
   output logic                busy,
   output logic                done,
   output logic                menor,
   output logic                igual,
   output logic                mayor,
   output logic                invalido
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] TOP = IW'(DIGITS - 1);

   typedef enum logic {IDLE, COMPARA} state_t;

   state_t              st, n_st;
   logic [IW-1:0]       idx, n_idx;
   logic [4*DIGITS-1:0] ra, rb, n_ra, n_rb;
   logic                pend, n_pend;
   logic                n_busy, n_done;
   logic                n_menor, n_igual, n_mayor, n_inv;
   logic                bad;
   logic [3:0]          da, db;

   assign da = ra[{idx, 2'b00} +: 4];
   assign db = rb[{idx, 2'b00} +: 4];

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9)
            bad = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= IDLE;
         idx      <= TOP;
         ra       <= '0;
         rb       <= '0;
         pend     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         menor    <= 1'b0;
         igual    <= 1'b0;
         mayor    <= 1'b0;
         invalido <= 1'b0;
      end else begin
         st       <= n_st;
         idx      <= n_idx;
         ra       <= n_ra;
         rb       <= n_rb;
         pend     <= n_pend;
         busy     <= n_busy;
         done     <= n_done;
         menor    <= n_menor;
         igual    <= n_igual;
         mayor    <= n_mayor;
         invalido <= n_inv;
      end
   end

   always_comb begin
      n_st    = st;
      n_idx   = idx;
      n_ra    = ra;
      n_rb    = rb;
      n_pend  = pend;
      n_busy  = busy;
      n_done  = 1'b0;
      n_menor = menor;
      n_igual = igual;
      n_mayor = mayor;
      n_inv   = invalido;
      unique case (st)
         IDLE: begin
            // Invalid request: one busy cycle in IDLE, then report.
            if (pend) begin
               n_pend = 1'b0;
               n_inv  = 1'b1;
               n_done = 1'b1;
               n_busy = 1'b0;
            end else if (start && !busy) begin
               n_ra    = A;
               n_rb    = B;
               n_idx   = TOP;
               n_menor = 1'b0;
               n_igual = 1'b0;
               n_mayor = 1'b0;
               n_inv   = 1'b0;
               n_busy  = 1'b1;
               if (bad)
                  n_pend = 1'b1;
               else
                  n_st = COMPARA;
            end
         end
         COMPARA: begin
            if (da != db || idx == '0) begin
               n_menor = (da < db);
               n_mayor = (da > db);
               n_igual = (da == db);
               n_done  = 1'b1;
               n_busy  = 1'b0;
               n_st    = IDLE;
            end else begin
               n_idx = idx - 1'b1;
            end
         end
         default: n_st = IDLE;
      endcase
   end

endmodule

// File: tb/tb_comparador_bcd_serial.sv
// Self-checking bench: vector table plus scoreboard queue,
// with hand sequences for abort, ignore and back-to-back cases.
module tb_comparador_bcd_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] A = '0, B = '0;
   logic        busy, done, menor, igual, mayor, invalido;

   logic        start1 = 1'b0;
   logic [3:0]  a1 = '0, b1 = '0;
   logic        busy1, done1, menor1, igual1, mayor1, invalido1;

   always #5 clk = ~clk;

   comparador_bcd_serial #(.DIGITS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .menor(menor), .igual(igual),
      .mayor(mayor), .invalido(invalido)
   );

   comparador_bcd_serial #(.DIGITS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
      .busy(busy1), .done(done1), .menor(menor1), .igual(igual1),
      .mayor(mayor1), .invalido(invalido1)
   );

   localparam logic [3:0] F_MEN = 4'b1000;
   localparam logic [3:0] F_IGU = 4'b0100;
   localparam logic [3:0] F_MAY = 4'b0010;
   localparam logic [3:0] F_INV = 4'b0001;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  f;
      int          lat;
   } vec_t;

   typedef struct {
      logic [3:0] f;
      int         lat;
   } exp_t;

   vec_t tv[10];
   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   function automatic logic [3:0] flags();
      return {menor, igual, mayor, invalido};
   endfunction

   task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, input int lat,
                          input string nm);
      int   cyc;
      exp_t e;
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      sbq.push_back('{f, lat});
      @(posedge clk);
      #1 start = 1'b0;
      chk({nm, " busy"}, int'(busy), 1);
      chk({nm, " flags0"}, int'(flags()), 0);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clk);
         #1 cyc++;
      end
      e = sbq.pop_front();
      chk({nm, " latency"}, cyc, e.lat);
      chk({nm, " flags"}, int'(flags()), int'(e.f));
      chk({nm, " busy_done"}, int'(busy), 0);
      @(posedge clk);
      #1 chk({nm, " done_pulse"}, int'(done), 0);
      chk({nm, " hold"}, int'(flags()), int'(e.f));
   endtask

   task automatic run_d1(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] f, input string nm);
      @(negedge clk);
      a1 = a;
      b1 = b;
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      chk({nm, " busy"}, int'(busy1), 1);
      @(posedge clk);
      #1 chk({nm, " done"}, int'(done1), 1);
      chk({nm, " flags"},
          int'({menor1, igual1, mayor1, invalido1}), int'(f));
   endtask

   initial begin
      int ndone, first, cyc;
      logic [3:0] fd;

      tv[0] = '{16'h1234, 16'h1299, F_MEN, 3};
      tv[1] = '{16'h9000, 16'h0999, F_MAY, 1};
      tv[2] = '{16'h5678, 16'h5678, F_IGU, 4};
      tv[3] = '{16'h12A4, 16'h0001, F_INV, 1};
      tv[4] = '{16'h12A4, 16'hF000, F_INV, 1};
      tv[5] = '{16'h0000, 16'h0001, F_MEN, 4};
      tv[6] = '{16'h0001, 16'h0000, F_MAY, 4};
      tv[7] = '{16'h9999, 16'h9998, F_MAY, 4};
      tv[8] = '{16'h0500, 16'h0600, F_MEN, 2};
      tv[9] = '{16'h0000, 16'h000A, F_INV, 1};

      repeat (2) @(posedge clk);
      #1 chk("reset outs", int'({busy, done, flags()}), 0);
      chk("reset outs d1",
          int'({busy1, done1, menor1, igual1, mayor1, invalido1}), 0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 10; i++)
         run_one(tv[i].a, tv[i].b, tv[i].f, tv[i].lat,
                 $sformatf("vec%0d", i));

      // Operand/start changes while busy must be ignored.
      @(negedge clk);
      A = 16'h0000;
      B = 16'h0001;
      start = 1'b1;
      @(posedge clk);
      #1 A = 16'h9999;
      ndone = 0;
      first = 0;
      fd = '0;
      for (cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 2) start = 1'b0;
         if (done) begin
            ndone++;
            if (first == 0) begin
               first = cyc;
               fd = flags();
            end
         end
      end
      chk("ign ndone", ndone, 1);
      chk("ign latency", first, 4);
      chk("ign flags", int'(fd), int'(F_MEN));

      // Reset mid-comparison aborts with no done.
      @(negedge clk);
      A = 16'h4444;
      B = 16'h4445;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("abort outs", int'({busy, done, flags()}), 0);
      ndone = 0;
      repeat (3) begin
         @(posedge clk);
         #1 if (done) ndone++;
      end
      chk("abort nodone", ndone, 0);
      @(negedge clk) rst = 1'b0;
      run_one(16'h0001, 16'h0000, F_MAY, 4, "post_rst");

      // start held high: back-to-back, busy low only on done.
      @(negedge clk);
      A = 16'h3000;
      B = 16'h2000;
      start = 1'b1;
      ndone = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1 chk($sformatf("b2b busy%0d", k), int'(busy), int'(!done));
         if (done) begin
            ndone++;
            chk($sformatf("b2b flags%0d", k), int'(flags()), int'(F_MAY));
         end
      end
      start = 1'b0;
      chk("b2b ndone", ndone, 5);
      repeat (2) @(posedge clk);

      run_d1(4'd7, 4'd7, F_IGU, "d1 eq");
      run_d1(4'd3, 4'd8, F_MEN, "d1 lt");
      run_d1(4'd9, 4'd2, F_MAY, "d1 gt");

      chk("sb empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
